// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller: FSM state encoding and default sizes.
package stack_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CAPT,
        ST_DONE
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

endpackage

// File: rtl/stack_ctrl.sv
// Stack controller driving an external synchronous RAM: push 2 cycles, pop/tos 3 cycles to done.
// Requests only taken in IDLE; anything arriving while busy is dropped. Macro STACK_BOUNDS_CHECK_EN adds ovf/unf.
// Reset: asynchronous active-low on rst.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] st_addr,
    output logic [DATA_W-1:0] st_wdata,
    output logic              st_we,
    input  logic [DATA_W-1:0] st_rdata
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] din_q;
    logic              pop_q;
    logic              acc_push;
    logic              acc_rd;
    logic              reject;
    logic              err_q;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W:0]   count_dec;

    assign acc_push  = (state == ST_IDLE) && push;
    assign acc_rd    = (state == ST_IDLE) && !push && (pop || tos);
    assign count_inc = count + {{ADDR_W{1'b0}}, 1'b1};
    assign count_dec = count - {{ADDR_W{1'b0}}, 1'b1};

    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);
    assign full  = (count == (ADDR_W+1)'(DEPTH));
    assign empty = (count == '0);

`ifdef STACK_BOUNDS_CHECK_EN
    logic ovf_q;
    logic unf_q;

    assign reject = (acc_push && full) || (acc_rd && empty);

    // Flags are sticky until reset; err_q marks the current operation as rejected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (acc_push || acc_rd) begin
            err_q <= reject;
            ovf_q <= ovf_q | (acc_push && full);
            unf_q <= unf_q | (acc_rd && empty);
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    assign reject = 1'b0;
    assign err_q  = 1'b0;
    assign ovf    = 1'b0;
    assign unf    = 1'b0;
`endif

    // Rejected requests pass through WRITE with the RAM write suppressed so that
    // done lands two cycles after the request, the same slot as a normal push.
    always_comb begin
        state_nxt = state;
        st_we     = 1'b0;
        st_addr   = count[ADDR_W-1:0];
        st_wdata  = din_q;
        case (state)
            ST_IDLE: begin
                if (acc_push || reject)
                    state_nxt = ST_WRITE;
                else if (acc_rd)
                    state_nxt = ST_READ;
            end
            ST_WRITE: begin
                st_we     = !err_q;
                state_nxt = ST_DONE;
            end
            ST_READ: begin
                st_addr   = count_dec[ADDR_W-1:0];
                state_nxt = ST_CAPT;
            end
            ST_CAPT:  state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            count <= '0;
            dout  <= '0;
            din_q <= '0;
            pop_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc_push)
                din_q <= din;
            if (acc_rd)
                pop_q <= pop;
            if (state == ST_WRITE && !err_q)
                count <= count_inc;
            // RAM data addressed in READ is valid during CAPT.
            if (state == ST_CAPT) begin
                dout <= st_rdata;
                if (pop_q)
                    count <= count_dec;
            end
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed scenarios plus randomized operations against a stack model.
module tb_stack_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              push = 1'b0, pop = 1'b0, tos = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic              busy, done, full, empty, ovf, unf, st_we;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] st_rdata = '0;

    stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
        .dout(dout), .busy(busy), .done(done), .full(full), .empty(empty),
        .ovf(ovf), .unf(unf), .count(count), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_we(st_we), .st_rdata(st_rdata)
    );

    always #5 clk = ~clk;

    // External RAM with one-cycle read latency, plus a log of observed writes.
    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] rd_addr_q = '0;
    int                wr_addr_q[$];
    int                wr_data_q[$];

    initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;

    always @(negedge clk) begin
        if (st_we) begin
            ram[st_addr] = st_wdata;
            wr_addr_q.push_back(int'(st_addr));
            wr_data_q.push_back(int'(st_wdata));
        end
        rd_addr_q = st_addr;
    end

    always @(posedge clk) st_rdata <= ram[rd_addr_q];

    // Reference model: stack contents by slot, entry count, last read value, flags.
    int                n_cmp = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_cnt = 0;
    logic [DATA_W-1:0] m_dout = '0;
    bit                m_ovf = 1'b0, m_unf = 1'b0;

    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    task automatic model_apply(input bit p, input bit q, input bit t, input logic [DATA_W-1:0] d,
                               output int e_lat, output bit e_we, output int e_addr);
        e_we = 1'b0; e_addr = 0; e_lat = -1;
        if (p) begin
            e_lat = 2;
            if (BOUNDS && m_cnt == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                e_we = 1'b1;
                e_addr = m_cnt % DEPTH;
                m_mem[e_addr] = d;
                m_cnt = (m_cnt + 1) % (2 * DEPTH);
            end
        end else if (q || t) begin
            if (BOUNDS && m_cnt == 0) begin
                m_unf = 1'b1;
                e_lat = 2;
            end else begin
                e_lat = 3;
                m_dout = m_mem[(m_cnt + 2 * DEPTH - 1) % DEPTH];
                if (q) m_cnt = (m_cnt + 2 * DEPTH - 1) % (2 * DEPTH);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0; m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Issues one request in an IDLE cycle and returns cycles from request to done (-1 on timeout).
    task automatic do_op(input bit p, input bit q, input bit t, input logic [DATA_W-1:0] d,
                         input bit junk, output int lat);
        @(negedge clk);
        wr_addr_q.delete(); wr_data_q.delete();
        push = p; pop = q; tos = t; din = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; din = DATA_W'($urandom);
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done) begin
                push = 1'b0; pop = 1'b0; tos = 1'b0;
                lat = k;
                break;
            end
            if (junk) begin
                push = 1'($urandom); pop = 1'($urandom); tos = 1'($urandom);
            end
        end
        push = 1'b0; pop = 1'b0; tos = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", dout); end
        n_cmp++; if ({busy, done, st_we, ovf, unf} !== 5'b0)
            begin n_err++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, st_we, ovf, unf}); end
        n_cmp++; if ({empty, full} !== 2'b10) begin n_err++; $display("FAIL reset_flags got %b want 10", {empty, full}); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_push_seq();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        int lat, el, ea; bit ew;
        for (int i = 0; i < 3; i++) begin
            model_apply(1, 0, 0, vals[i], el, ew, ea);
            do_op(1, 0, 0, vals[i], 0, lat);
            n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL push_latency[%0d] got %0d want 2", i, lat); end
            n_cmp++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != i || wr_data_q[0] != int'(vals[i]))
                begin n_err++; $display("FAIL push_write[%0d] got %0d writes want 1 at addr %0d", i, wr_addr_q.size(), i); end
        end
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL push_count got %0d want 3", count); end
    endtask

    task automatic test_tos_pop();
        logic [7:0] exp [3] = '{8'h33, 8'h22, 8'h11};
        int lat, el, ea; bit ew;
        model_apply(0, 0, 1, '0, el, ew, ea);
        do_op(0, 0, 1, '0, 0, lat);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL tos_latency got %0d want 3", lat); end
        n_cmp++; if (dout !== 8'h33 || count !== 4'd3)
            begin n_err++; $display("FAIL tos_result got dout=%h count=%0d want 33/3", dout, count); end
        for (int i = 0; i < 3; i++) begin
            model_apply(0, 1, 0, '0, el, ew, ea);
            do_op(0, 1, 0, '0, 0, lat);
            n_cmp++; if (lat !== 3 || dout !== exp[i] || wr_addr_q.size() != 0)
                begin n_err++; $display("FAIL pop[%0d] got lat=%0d dout=%h want 3/%h", i, lat, dout, exp[i]); end
        end
        n_cmp++; if (empty !== 1'b1 || count !== 4'd0)
            begin n_err++; $display("FAIL pop_empty got empty=%b count=%0d want 1/0", empty, count); end
    endtask

    task automatic test_priority();
        int lat, el, ea; bit ew;
        apply_reset();
        model_apply(1, 1, 1, 8'h5A, el, ew, ea);
        do_op(1, 1, 1, 8'h5A, 1, lat);
        n_cmp++; if (count !== 4'd1 || lat !== 2)
            begin n_err++; $display("FAIL priority got count=%0d lat=%0d want 1/2", count, lat); end
        n_cmp++; if (wr_addr_q.size() != 1 || wr_data_q[0] != 'h5A)
            begin n_err++; $display("FAIL priority_write got %0d writes want one of 5a", wr_addr_q.size()); end
        // A pop arriving mid-push must be dropped.
        model_apply(1, 0, 0, 8'h6B, el, ew, ea);
        @(negedge clk);
        push = 1'b1; din = 8'h6B;
        @(posedge clk); #1; push = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_write got %b want 1", busy); end
        pop = 1'b1;
        @(negedge clk); pop = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (count !== 4'd2 || busy !== 1'b0)
            begin n_err++; $display("FAIL ignore_busy got count=%0d busy=%b want 2/0", count, busy); end
    endtask

    task automatic test_reset_mid_op();
        int lat, el, ea; bit ew;
        apply_reset();
        model_apply(1, 0, 0, 8'h44, el, ew, ea);
        do_op(1, 0, 0, 8'h44, 0, lat);
        @(negedge clk);
        pop = 1'b1;
        @(posedge clk); #1; pop = 1'b0;
        @(negedge clk);
        n_cmp++; if (st_addr !== 3'd0 || busy !== 1'b1)
            begin n_err++; $display("FAIL read_addr got %0d busy=%b want 0/1", st_addr, busy); end
        wr_addr_q.delete();
        rst = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0 || dout !== 8'h00 || busy !== 1'b0)
            begin n_err++; $display("FAIL abort got count=%0d dout=%h busy=%b want 0/00/0", count, dout, busy); end
        m_cnt = 0; m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_cmp++; if (wr_addr_q.size() != 0) begin n_err++; $display("FAIL abort_write got %0d writes want 0", wr_addr_q.size()); end
        model_apply(1, 0, 0, 8'h77, el, ew, ea);
        do_op(1, 0, 0, 8'h77, 0, lat);
        n_cmp++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != 0 || lat !== 2)
            begin n_err++; $display("FAIL post_reset_push got %0d writes lat=%0d want addr 0 lat 2", wr_addr_q.size(), lat); end
    endtask

`ifdef STACK_BOUNDS_CHECK_EN
    task automatic test_bounds();
        int lat, el, ea; bit ew;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            model_apply(1, 0, 0, 8'(i + 1), el, ew, ea);
            do_op(1, 0, 0, 8'(i + 1), 0, lat);
        end
        model_apply(1, 0, 0, 8'hAA, el, ew, ea);
        do_op(1, 0, 0, 8'hAA, 0, lat);
        n_cmp++; if (wr_addr_q.size() != 0 || ovf !== 1'b1 || lat !== 2 || count !== 4'd8)
            begin n_err++; $display("FAIL overflow got writes=%0d ovf=%b lat=%0d count=%0d want 0/1/2/8", wr_addr_q.size(), ovf, lat, count); end
        for (int i = 0; i < 8; i++) begin
            model_apply(0, 1, 0, '0, el, ew, ea);
            do_op(0, 1, 0, '0, 0, lat);
        end
        model_apply(0, 1, 0, '0, el, ew, ea);
        do_op(0, 1, 0, '0, 0, lat);
        n_cmp++; if (unf !== 1'b1 || dout !== 8'h01 || lat !== 2 || ovf !== 1'b1 || count !== 4'd0)
            begin n_err++; $display("FAIL underflow got unf=%b dout=%h lat=%0d want 1/01/2", unf, dout, lat); end
    endtask
`else
    task automatic test_wrap();
        int lat, el, ea; bit ew;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            model_apply(1, 0, 0, 8'(8'hA0 + i), el, ew, ea);
            do_op(1, 0, 0, 8'(8'hA0 + i), 0, lat);
        end
        n_cmp++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != 0 || wr_data_q[0] != 'hA8)
            begin n_err++; $display("FAIL wrap_write got %0d writes want one at addr 0", wr_addr_q.size()); end
        n_cmp++; if (ovf !== 1'b0 || count !== 4'd9 || full !== 1'b0)
            begin n_err++; $display("FAIL wrap_state got ovf=%b count=%0d full=%b want 0/9/0", ovf, count, full); end
    endtask
`endif

    task automatic test_random();
        int lat, el, ea; bit ew;
        bit p, q, t, junk;
        logic [7:0] d;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            do begin
                p = ($urandom_range(0, 2) == 0); q = 1'($urandom); t = 1'($urandom);
            end while (!(p || q || t));
            d = 8'($urandom);
            junk = 1'($urandom);
            model_apply(p, q, t, d, el, ew, ea);
            do_op(p, q, t, d, junk, lat);
            n_cmp++; if (lat !== el) begin n_err++; $display("FAIL rnd_latency[%0d] got %0d want %0d", n, lat, el); end
            n_cmp++; if (int'(count) != m_cnt || dout !== m_dout)
                begin n_err++; $display("FAIL rnd_state[%0d] got count=%0d dout=%h want %0d/%h", n, count, dout, m_cnt, m_dout); end
            n_cmp++; if (empty !== (m_cnt == 0) || full !== (m_cnt == DEPTH) || ovf !== m_ovf || unf !== m_unf)
                begin n_err++; $display("FAIL rnd_flags[%0d] got e=%b f=%b o=%b u=%b", n, empty, full, ovf, unf); end
            n_cmp++; if (wr_addr_q.size() != int'(ew) || (ew && (wr_addr_q[0] != ea || wr_data_q[0] != int'(d))))
                begin n_err++; $display("FAIL rnd_write[%0d] got %0d writes want %0d at addr %0d", n, wr_addr_q.size(), ew, ea); end
        end
    endtask

    initial begin
        test_reset();
        test_push_seq();
        test_tos_pop();
        test_priority();
        test_reset_mid_op();
`ifdef STACK_BOUNDS_CHECK_EN
        test_bounds();
`else
        test_wrap();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
